accum_stream_packer: RTL and testbench
======================================

Name: accum_stream_packer

Overview:
- Producer side of the 25-bit accumulator stream: bit 24 is the group-end flag, and a word of 25'h0 marks an empty group.
- Accepts one group of up to 4 parallel 24-bit partial sums over a valid/ready handshake.
- Serializes the group one word per cycle.
- Feeds the accumulator/controller input (accum_in) of the sparse-MAC datapath.

Parameters:
- DATA_W, 24, payload width; stream word is DATA_W+1 bits with the flag in the MSB.
- GAP_CYCLES, 0, idle cycles forced between groups (0..15).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- in_valid  input  1  group offered
- in_ready  output  1  packer can accept a group
- in_count  input  3  number of elements in group, 0..4; values 5..7 are clamped to 4
- in_data1..in_data4  input  DATA_W each  elements, sent in order 1..4
- out_data  output  DATA_W+1  stream word {last, payload}
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data this cycle
- busy  output  1  state != IDLE
- group_cnt  output  4  groups fully sent, wraps 15->0

Behaviour:
- Reset (async, active-low): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, group_cnt=0, all holding registers cleared. A group in flight is dropped with no partial flush.
- States: IDLE, SEND, GAP.
- Accept rule:
  - in_ready=1 only in IDLE.
  - Accept happens when in_valid & in_ready at an edge.
  - At accept: latch the 4 data words into hold regs, latch the clamped count, build the send mask (bit i set when i < count and element i is to be sent), then go to SEND.
- SEND:
  - out_valid=1.
  - out_data = {last, hold[idx]}, where idx is the lowest set mask bit and last=1 when idx is the highest set mask bit.
  - Word changes only when out_valid & out_ready at an edge; that transfer clears mask bit idx.
  - out_data is registered, so the first word is valid the cycle after accept (latency 1).
- Empty group: if the mask is empty at accept (count=0, or all elements skipped), SEND emits exactly one word, 25'h0 (last=0, payload 0), which is the empty-group marker.
- End of group:
  - On transfer of the last word (or the empty marker): group_cnt+1.
  - Then go to GAP if GAP_CYCLES>0, else IDLE.
  - in_ready rises the cycle after the final transfer, so the minimum group period is words+1 cycles.
- GAP: out_valid=0, in_ready=0; a down-counter loads GAP_CYCLES and returns to IDLE when it reaches 1.
- out_data when out_valid=0: held at 25'h0.
- Backpressure: while out_valid & !out_ready, out_data is held stable and the mask is unchanged, for any stall length.
- in_valid outside IDLE is ignored; the upstream must hold it.
- Simultaneous events:
  - Final transfer and in_valid in the same cycle: the new group is not accepted that cycle.
  - Reset asserted during SEND wins immediately (async clear).
- Width: payload is passed unmodified; no arithmetic on data; group_cnt wraps modulo 16.

Optional Feature:
- Macro PACK_SKIP_ZERO_EN.
- Defined:
  - Elements with payload == 0 are excluded from the mask at accept, so no zero-valued non-last word can appear on the stream and alias the 25'h0 marker.
  - The last surviving element carries bit 24.
  - If all elements are zero, the single 25'h0 marker is sent.
- Undefined:
  - The mask depends on count only, and zero payloads are sent as-is.
  - A zero non-last element produces 25'h0 on the bus; avoiding this is the upstream's responsibility.

Test Plan:
- Count=3, data 0x000011/0x000022/0x000033, out_ready=1 -> out words 0x0000011, 0x0000022, 0x1000033 on 3 consecutive cycles starting 1 cycle after accept; group_cnt=1; in_ready=1 the next cycle.
- Count=4, out_ready low for 5 cycles during the 2nd word -> 2nd word held stable 5 cycles, all 4 words delivered in order, last = 0x1xxxxxx.
- Count=0 -> single word 25'h0 with out_valid=1 for one cycle; group_cnt increments.
- PACK_SKIP_ZERO_EN defined, count=4, data 5,0,7,0 -> words 0x0000005, 0x1000007 only. Undefined -> 0x0000005, 0x0000000, 0x0000007, 0x1000000.
- GAP_CYCLES=3, back-to-back groups with in_valid held -> out_valid low exactly 3 cycles plus the 1 accept cycle between groups.
- reset driven low mid-SEND (word 2 of 4) -> out_valid=0 and group_cnt=0 immediately, before the next clock edge; after release, in_ready=1 and a new count=1 group emits 0x1000abc.

Source files
------------

// File: rtl/accum_stream_packer_if.sv
// Handshake bundle between a group producer and the accumulator stream.
// Carries the parallel group inputs and the serialized 25-bit stream.
interface accum_stream_packer_if #(
  parameter int DATA_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_count;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] in_data3;
  logic [DATA_W-1:0] in_data4;
  logic [DATA_W:0]   out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_count,
    output in_data1,
    output in_data2,
    output in_data3,
    output in_data4,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_count,
    input  in_data1,
    input  in_data2,
    input  in_data3,
    input  in_data4,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/accum_stream_packer.sv
// Packs a group of up to 4 partial sums into a {last,payload} word stream.
// Optional macro PACK_SKIP_ZERO_EN drops zero-valued elements at accept.
module accum_stream_packer #(
  parameter int DATA_W     = 24,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clock,
  input  logic       reset,
  accum_stream_packer_if.slave bus,
  output logic       busy,
  output logic [3:0] group_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [3:0] GAP_L = 4'(GAP_CYCLES);

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] hold_q [4];
  logic [DATA_W-1:0] hold_d [4];
  logic [3:0]        mask_q;
  logic [3:0]        mask_d;
  logic [3:0]        gap_q;
  logic [3:0]        gap_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic [DATA_W:0]   word_q;
  logic [DATA_W:0]   word_d;

  logic [2:0]        cnt_clamp;
  logic [3:0]        in_mask;
  logic [1:0]        idx_q;
  logic [1:0]        idx_d;

  function automatic logic [1:0] low_idx(
    input logic [3:0] m
  );
    logic [1:0] r;
    priority case (1'b1)
      m[0]:    r = 2'd0;
      m[1]:    r = 2'd1;
      m[2]:    r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Single remaining bit means the current word closes the group.
  function automatic logic is_last(
    input logic [3:0] m
  );
    return (m != 4'd0) &&
           ((m & (m - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    cnt_clamp = bus.in_count;
    if (bus.in_count > 3'd4) begin
      cnt_clamp = 3'd4;
    end
  end

  always_comb begin
    in_mask = 4'b1111 >> (3'd4 - cnt_clamp);
`ifdef PACK_SKIP_ZERO_EN
    if (bus.in_data1 == '0) in_mask[0] = 1'b0;
    if (bus.in_data2 == '0) in_mask[1] = 1'b0;
    if (bus.in_data3 == '0) in_mask[2] = 1'b0;
    if (bus.in_data4 == '0) in_mask[3] = 1'b0;
`else
    in_mask = in_mask;
`endif
  end

  always_comb begin
    idx_q = low_idx(mask_q);
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = SEND;
          mask_d    = in_mask;
          hold_d[0] = bus.in_data1;
          hold_d[1] = bus.in_data2;
          hold_d[2] = bus.in_data3;
          hold_d[3] = bus.in_data4;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (mask_q == 4'd0 ||
              is_last(mask_q)) begin
            cnt_d  = cnt_q + 4'd1;
            mask_d = '0;
            if (GAP_L != 4'd0) begin
              state_d = GAP;
              gap_d   = GAP_L;
            end else begin
              state_d = IDLE;
            end
          end else begin
            mask_d = mask_q &
                     ~(4'b0001 << idx_q);
          end
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next stream word is built ahead so out_data comes straight from a flop.
  always_comb begin
    idx_d  = low_idx(mask_d);
    word_d = '0;
    if (state_d == SEND &&
        mask_d != 4'd0) begin
      word_d = {is_last(mask_d),
                hold_d[idx_d]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = word_q;
  assign busy          = (state_q != IDLE);
  assign group_cnt     = cnt_q;

endmodule

// File: tb/tb_accum_stream_packer.sv
// Directed bench for accum_stream_packer: GAP_CYCLES=0 and =3 instances.
// Expected stream words are hand-computed per scenario.
module tb_accum_stream_packer;

  logic       clock;
  logic       reset;
  logic       busy0;
  logic       busy3;
  logic [3:0] gc0;
  logic [3:0] gc3;

  int errors;
  int checks;

  accum_stream_packer_if #(.DATA_W(24)) bus0 ();
  accum_stream_packer_if #(.DATA_W(24)) bus3 ();

  accum_stream_packer #(
    .DATA_W(24),
    .GAP_CYCLES(0)
  ) dut0 (
    .clock(clock),
    .reset(reset),
    .bus(bus0),
    .busy(busy0),
    .group_cnt(gc0)
  );

  accum_stream_packer #(
    .DATA_W(24),
    .GAP_CYCLES(3)
  ) dut3 (
    .clock(clock),
    .reset(reset),
    .bus(bus3),
    .busy(busy3),
    .group_cnt(gc3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer0(
    input logic [2:0]  cnt,
    input logic [23:0] d1,
    input logic [23:0] d2,
    input logic [23:0] d3,
    input logic [23:0] d4
  );
    bus0.in_valid = 1'b1;
    bus0.in_count = cnt;
    bus0.in_data1 = d1;
    bus0.in_data2 = d2;
    bus0.in_data3 = d3;
    bus0.in_data4 = d4;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({bus0.in_ready, bus0.out_valid,
         busy0, gc0} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_ctl got rdy=%b vld=%b busy=%b gc=%0d exp 1 0 0 0",
               bus0.in_ready, bus0.out_valid, busy0, gc0);
    end
    checks++;
    if (bus0.out_data !== 25'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=%h", bus0.out_data, 25'h0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [24:0] exp [3];
    exp[0] = 25'h0000011;
    exp[1] = 25'h0000022;
    exp[2] = 25'h1000033;
    offer0(3'd3, 24'h11, 24'h22, 24'h33, 24'h0);
    tick();
    bus0.in_valid = 1'b0;
    checks++;
    if ({bus0.in_ready, busy0} !== 2'b01) begin
      errors++;
      $display("FAIL basic_send_ctl got rdy=%b busy=%b exp rdy=0 busy=1",
               bus0.in_ready, busy0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL basic_w%0d got vld=%b data=%h exp vld=1 data=%h",
                 i, bus0.out_valid, bus0.out_data, exp[i]);
      end
      tick();
    end
    checks++;
    if ({bus0.in_ready, bus0.out_valid, gc0} !== {1'b1, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL basic_end got rdy=%b vld=%b gc=%0d exp 1 0 1",
               bus0.in_ready, bus0.out_valid, gc0);
    end
  endtask

  task automatic test_backpressure();
    logic [24:0] exp [4];
    exp[0] = 25'h00A0001;
    exp[1] = 25'h00A0002;
    exp[2] = 25'h00A0003;
    exp[3] = 25'h10A0004;
    offer0(3'd4, 24'hA0001, 24'hA0002, 24'hA0003, 24'hA0004);
    tick();
    bus0.in_valid = 1'b0;
    checks++;
    if (bus0.out_data !== exp[0]) begin
      errors++;
      $display("FAIL bp_w0 got=%h exp=%h", bus0.out_data, exp[0]);
    end
    tick();
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_data} !== {1'b1, exp[1]}) begin
        errors++;
        $display("FAIL bp_stall%0d got vld=%b data=%h exp vld=1 data=%h",
                 i, bus0.out_valid, bus0.out_data, exp[1]);
      end
      if (i < 5) tick();
    end
    bus0.out_ready = 1'b1;
    tick();
    for (int i = 2; i < 4; i++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL bp_w%0d got vld=%b data=%h exp vld=1 data=%h",
                 i, bus0.out_valid, bus0.out_data, exp[i]);
      end
      tick();
    end
    checks++;
    if ({bus0.out_valid, gc0} !== {1'b0, 4'd2}) begin
      errors++;
      $display("FAIL bp_end got vld=%b gc=%0d exp vld=0 gc=2",
               bus0.out_valid, gc0);
    end
  endtask

  task automatic test_empty();
    offer0(3'd0, 24'h123456, 24'h1, 24'h2, 24'h3);
    tick();
    bus0.in_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.out_data} !== {1'b1, 25'h0}) begin
      errors++;
      $display("FAIL empty_marker got vld=%b data=%h exp vld=1 data=0000000",
               bus0.out_valid, bus0.out_data);
    end
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready, gc0} !== {1'b0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL empty_end got vld=%b rdy=%b gc=%0d exp 0 1 3",
               bus0.out_valid, bus0.in_ready, gc0);
    end
  endtask

  task automatic test_clamp();
    logic [24:0] exp [4];
    exp[0] = 25'h0000001;
    exp[1] = 25'h0000002;
    exp[2] = 25'h0000003;
    exp[3] = 25'h1000004;
    offer0(3'd7, 24'h1, 24'h2, 24'h3, 24'h4);
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL clamp_w%0d got vld=%b data=%h exp vld=1 data=%h",
                 i, bus0.out_valid, bus0.out_data, exp[i]);
      end
      tick();
    end
    checks++;
    if ({bus0.out_valid, gc0} !== {1'b0, 4'd4}) begin
      errors++;
      $display("FAIL clamp_end got vld=%b gc=%0d exp vld=0 gc=4",
               bus0.out_valid, gc0);
    end
  endtask

  task automatic test_skip_zero();
    logic [24:0] exp [4];
    int n;
`ifdef PACK_SKIP_ZERO_EN
    n = 2;
    exp[0] = 25'h0000005;
    exp[1] = 25'h1000007;
    exp[2] = 25'h0;
    exp[3] = 25'h0;
`else
    n = 4;
    exp[0] = 25'h0000005;
    exp[1] = 25'h0000000;
    exp[2] = 25'h0000007;
    exp[3] = 25'h1000000;
`endif
    offer0(3'd4, 24'h5, 24'h0, 24'h7, 24'h0);
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL skip_w%0d got vld=%b data=%h exp vld=1 data=%h",
                 i, bus0.out_valid, bus0.out_data, exp[i]);
      end
      tick();
    end
    checks++;
    if ({bus0.out_valid, gc0} !== {1'b0, 4'd5}) begin
      errors++;
      $display("FAIL skip_end got vld=%b gc=%0d exp vld=0 gc=5",
               bus0.out_valid, gc0);
    end
  endtask

  task automatic test_back_to_back();
    offer0(3'd1, 24'h55, 24'h0, 24'h0, 24'h0);
    tick();
    checks++;
    if ({bus0.out_valid, bus0.out_data} !== {1'b1, 25'h1000055}) begin
      errors++;
      $display("FAIL b2b_g1 got vld=%b data=%h exp vld=1 data=1000055",
               bus0.out_valid, bus0.out_data);
    end
    tick();
    checks++;
    if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle got vld=%b rdy=%b exp vld=0 rdy=1",
               bus0.out_valid, bus0.in_ready);
    end
    tick();
    bus0.in_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.out_data} !== {1'b1, 25'h1000055}) begin
      errors++;
      $display("FAIL b2b_g2 got vld=%b data=%h exp vld=1 data=1000055",
               bus0.out_valid, bus0.out_data);
    end
    tick();
    checks++;
    if ({bus0.out_valid, gc0} !== {1'b0, 4'd7}) begin
      errors++;
      $display("FAIL b2b_end got vld=%b gc=%0d exp vld=0 gc=7",
               bus0.out_valid, gc0);
    end
  endtask

  task automatic test_gap();
    int zeros;
    bus3.in_valid = 1'b1;
    bus3.in_count = 3'd1;
    bus3.in_data1 = 24'h77;
    tick();
    checks++;
    if ({bus3.out_valid, bus3.out_data} !== {1'b1, 25'h1000077}) begin
      errors++;
      $display("FAIL gap_g1 got vld=%b data=%h exp vld=1 data=1000077",
               bus3.out_valid, bus3.out_data);
    end
    tick();
    checks++;
    if ({bus3.out_valid, bus3.in_ready, busy3, gc3} !==
        {1'b0, 1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL gap_state got vld=%b rdy=%b busy=%b gc=%0d exp 0 0 1 1",
               bus3.out_valid, bus3.in_ready, busy3, gc3);
    end
    zeros = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus3.out_valid) break;
      zeros++;
    end
    bus3.in_valid = 1'b0;
    checks++;
    if (zeros !== 4) begin
      errors++;
      $display("FAIL gap_len got=%0d idle cycles exp=4", zeros);
    end
    checks++;
    if ({bus3.out_valid, bus3.out_data} !== {1'b1, 25'h1000077}) begin
      errors++;
      $display("FAIL gap_g2 got vld=%b data=%h exp vld=1 data=1000077",
               bus3.out_valid, bus3.out_data);
    end
    tick();
    checks++;
    if (gc3 !== 4'd2) begin
      errors++;
      $display("FAIL gap_cnt got=%0d exp=2", gc3);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_send();
    offer0(3'd4, 24'h100, 24'h200, 24'h300, 24'h400);
    tick();
    bus0.in_valid = 1'b0;
    tick();
    checks++;
    if ({bus0.out_valid, bus0.out_data, gc0} !==
        {1'b1, 25'h0000200, 4'd7}) begin
      errors++;
      $display("FAIL rst_pre got vld=%b data=%h gc=%0d exp 1 0000200 7",
               bus0.out_valid, bus0.out_data, gc0);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus0.out_valid, bus0.in_ready, busy0, gc0, gc3} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL rst_async got vld=%b rdy=%b busy=%b gc0=%0d gc3=%0d exp 0 1 0 0 0",
               bus0.out_valid, bus0.in_ready, busy0, gc0, gc3);
    end
    checks++;
    if (bus0.out_data !== 25'h0) begin
      errors++;
      $display("FAIL rst_data got=%h exp=0000000", bus0.out_data);
    end
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if ({bus0.in_ready, bus0.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_release got rdy=%b vld=%b exp rdy=1 vld=0",
               bus0.in_ready, bus0.out_valid);
    end
    offer0(3'd1, 24'habc, 24'h0, 24'h0, 24'h0);
    tick();
    bus0.in_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.out_data} !== {1'b1, 25'h1000abc}) begin
      errors++;
      $display("FAIL rst_new got vld=%b data=%h exp vld=1 data=1000abc",
               bus0.out_valid, bus0.out_data);
    end
    tick();
    checks++;
    if ({bus0.out_valid, gc0} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL rst_new_end got vld=%b gc=%0d exp vld=0 gc=1",
               bus0.out_valid, gc0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_count  = 3'd0;
    bus0.in_data1  = '0;
    bus0.in_data2  = '0;
    bus0.in_data3  = '0;
    bus0.in_data4  = '0;
    bus0.out_ready = 1'b1;
    bus3.in_valid  = 1'b0;
    bus3.in_count  = 3'd0;
    bus3.in_data1  = '0;
    bus3.in_data2  = '0;
    bus3.in_data3  = '0;
    bus3.in_data4  = '0;
    bus3.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_clamp();
    test_skip_zero();
    test_back_to_back();
    test_gap();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
